// File: rtl/fft_mag_pkg.sv
// fft_mag_pkg: shared types and helpers for the FFT magnitude buffer.
// FSM states, width constants and the output saturation function.
package fft_mag_pkg;

  localparam int DW_DEF = 24;
  localparam int OW     = 32;
  localparam int SUMW   = 2*DW_DEF + 1;

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    READY
  } state_e;

  function automatic logic [OW-1:0] saturate(
    input logic [SUMW-1:0] v
  );
    if (|v[SUMW-1:OW]) return '1;
    return v[OW-1:0];
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: 3-stage re^2+im^2 pipeline with shift and saturation.
// Stage 3 is combinational and feeds the RAM write port directly.
module fft_mag_sq
  import fft_mag_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = 8,
  parameter int SHIFT = 17
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  input  logic [AW-1:0]   in_addr_i,
  input  logic [2*DW-1:0] in_data_i,
  output logic            busy_o,
  output logic            wr_en_o,
  output logic [AW-1:0]   wr_addr_o,
  output logic [OW-1:0]   wr_data_o
);

  logic                   v1_q, v2_q;
  logic [AW-1:0]          a1_q, a2_q;
  logic signed [DW-1:0]   re1_q, im1_q;
  logic [2*DW-1:0]        rr2_q, ii2_q;
  logic signed [2*DW-1:0] re_x, im_x;
  logic signed [2*DW-1:0] rr_d, ii_d;
  logic [2*DW:0]          sum_w;
  logic [2*DW:0]          shr_w;

  assign re_x = (2*DW)'(re1_q);
  assign im_x = (2*DW)'(im1_q);
  assign rr_d = re_x * re_x;
  assign ii_d = im_x * im_x;

  // S1 captures the components, S2 registers the squares
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      a1_q  <= '0;
      a2_q  <= '0;
      re1_q <= '0;
      im1_q <= '0;
      rr2_q <= '0;
      ii2_q <= '0;
    end else begin
      v1_q  <= in_valid_i;
      a1_q  <= in_addr_i;
      re1_q <= in_data_i[DW-1:0];
      im1_q <= in_data_i[2*DW-1:DW];
      v2_q  <= v1_q;
      a2_q  <= a1_q;
      rr2_q <= rr_d;
      ii2_q <= ii_d;
    end
  end

  assign sum_w     = {1'b0, rr2_q} + {1'b0, ii2_q};
  assign shr_w     = sum_w >> SHIFT;
  assign wr_data_o = saturate(SUMW'(shr_w));
  assign wr_en_o   = v2_q;
  assign wr_addr_o = a2_q;
  assign busy_o    = v1_q | v2_q;

endmodule

// File: rtl/fft_mag_buffer.sv
// fft_mag_buffer: frame buffer of scaled |X|^2 for software readout.
// Optional peak tracking is enabled with `define FFT_MAG_PEAK_EN.
module fft_mag_buffer
  import fft_mag_pkg::*;
#(
  parameter int N_BINS  = 256,
  parameter int DW      = DW_DEF,
  parameter int SHIFT   = 17,
  localparam int AW     = $clog2(N_BINS)
) (
  input  logic            Bus2IP_Clk,
  input  logic            Bus2IP_Resetn,
  input  logic [2*DW-1:0] s_axis_tdata,
  input  logic            s_axis_tvalid,
  input  logic            s_axis_tlast,
  output logic            s_axis_tready,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [OW-1:0]   rd_data,
  input  logic            frame_clr,
  output logic            frame_ready,
  output logic [AW:0]     frame_len,
  output logic            err_tlast_early,
  output logic            err_tlast_missing,
  output logic [AW-1:0]   peak_bin,
  output logic [OW-1:0]   peak_mag
);

  localparam logic [AW-1:0] LAST = AW'(N_BINS - 1);

  state_e          state_q;
  logic            rdy_q;
  logic [AW-1:0]   bin_cnt_q;
  logic            frame_ready_q;
  logic [AW:0]     frame_len_q;
  logic            err_early_q;
  logic            err_miss_q;
  logic [OW-1:0]   rd_data_q;
  logic [OW-1:0]   ram_q [N_BINS];

  logic            accept;
  logic            release_w;
  logic            busy;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [OW-1:0]   wr_data;

  assign s_axis_tready = rdy_q && (state_q == FILL);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign release_w     = (state_q == READY) && frame_clr;

  fft_mag_sq #(
    .DW    (DW),
    .AW    (AW),
    .SHIFT (SHIFT)
  ) u_sq (
    .clk_i      (Bus2IP_Clk),
    .rst_ni     (Bus2IP_Resetn),
    .in_valid_i (accept),
    .in_addr_i  (bin_cnt_q),
    .in_data_i  (s_axis_tdata),
    .busy_o     (busy),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data)
  );

  // hold tready low for the first cycle out of reset
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) rdy_q <= 1'b0;
    else                rdy_q <= 1'b1;
  end

  // frame FSM: fill, drain the pipeline, hold until released
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q       <= FILL;
      bin_cnt_q     <= '0;
      frame_ready_q <= 1'b0;
      frame_len_q   <= '0;
      err_early_q   <= 1'b0;
      err_miss_q    <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            bin_cnt_q <= bin_cnt_q + 1'b1;
            if (s_axis_tlast) begin
              state_q     <= DRAIN;
              frame_len_q <= {1'b0, bin_cnt_q} + (AW+1)'(1);
              if (bin_cnt_q != LAST) err_early_q <= 1'b1;
            end else if (bin_cnt_q == LAST) begin
              state_q     <= DRAIN;
              frame_len_q <= (AW+1)'(N_BINS);
              err_miss_q  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!busy) begin
            state_q       <= READY;
            frame_ready_q <= 1'b1;
          end
        end
        READY: begin
          if (frame_clr) begin
            state_q       <= FILL;
            bin_cnt_q     <= '0;
            frame_ready_q <= 1'b0;
            err_early_q   <= 1'b0;
            err_miss_q    <= 1'b0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // bin RAM write port, contents survive reset
  always_ff @(posedge Bus2IP_Clk) begin
    if (wr_en) ram_q[wr_addr] <= wr_data;
  end

  // registered read port, old data on a same-address write
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) rd_data_q <= '0;
    else if (rd_en)     rd_data_q <= ram_q[rd_addr];
  end

  assign rd_data           = rd_data_q;
  assign frame_ready       = frame_ready_q;
  assign frame_len         = frame_len_q;
  assign err_tlast_early   = err_early_q;
  assign err_tlast_missing = err_miss_q;

`ifdef FFT_MAG_PEAK_EN
  logic [AW-1:0] peak_bin_q;
  logic [OW-1:0] peak_mag_q;

  // strict compare so the lowest bin wins a tie
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else if (release_w) begin
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else if (wr_en && (wr_data > peak_mag_q)) begin
      peak_bin_q <= wr_addr;
      peak_mag_q <= wr_data;
    end
  end

  assign peak_bin = peak_bin_q;
  assign peak_mag = peak_mag_q;
`else
  logic unused_peak;
  assign unused_peak = release_w;
  assign peak_bin    = '0;
  assign peak_mag    = '0;
`endif

endmodule

// File: tb/tb_fft_mag_buffer.sv
// tb_fft_mag_buffer: scoreboard bench for the FFT magnitude buffer.
// DUT A uses defaults; DUT B is a 4-bin, SHIFT=0 build for saturation.
module tb_fft_mag_buffer;

  localparam int AW  = 8;
  localparam int BAW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [47:0]   tdata;
  logic          tvalid, tlast, tready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          frame_clr, frame_ready;
  logic [AW:0]   frame_len;
  logic          err_e, err_m;
  logic [AW-1:0] peak_bin;
  logic [31:0]   peak_mag;

  logic [47:0]    b_tdata;
  logic           b_tvalid, b_tlast, b_tready;
  logic           b_rd_en;
  logic [BAW-1:0] b_rd_addr;
  logic [31:0]    b_rd_data;
  logic           b_frame_clr, b_frame_ready;
  logic [BAW:0]   b_frame_len;
  logic           b_err_e, b_err_m;
  logic [BAW-1:0] b_peak_bin;
  logic [31:0]    b_peak_mag;

  fft_mag_buffer u_dut (
    .Bus2IP_Clk        (clk),
    .Bus2IP_Resetn     (rst_n),
    .s_axis_tdata      (tdata),
    .s_axis_tvalid     (tvalid),
    .s_axis_tlast      (tlast),
    .s_axis_tready     (tready),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .frame_clr         (frame_clr),
    .frame_ready       (frame_ready),
    .frame_len         (frame_len),
    .err_tlast_early   (err_e),
    .err_tlast_missing (err_m),
    .peak_bin          (peak_bin),
    .peak_mag          (peak_mag)
  );

  fft_mag_buffer #(.N_BINS(4), .SHIFT(0)) u_dut_b (
    .Bus2IP_Clk        (clk),
    .Bus2IP_Resetn     (rst_n),
    .s_axis_tdata      (b_tdata),
    .s_axis_tvalid     (b_tvalid),
    .s_axis_tlast      (b_tlast),
    .s_axis_tready     (b_tready),
    .rd_en             (b_rd_en),
    .rd_addr           (b_rd_addr),
    .rd_data           (b_rd_data),
    .frame_clr         (b_frame_clr),
    .frame_ready       (b_frame_ready),
    .frame_len         (b_frame_len),
    .err_tlast_early   (b_err_e),
    .err_tlast_missing (b_err_m),
    .peak_bin          (b_peak_bin),
    .peak_mag          (b_peak_mag)
  );

  typedef struct {
    int          addr;
    logic [31:0] mag;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          fails = 0;
  logic [31:0] exp_pmag;
  int          exp_pbin;
  logic [31:0] last_rd;
  logic [31:0] stale_200;

  function automatic logic [31:0] mag_model(input int re, input int im,
                                            input int sh);
    longint s;
    s = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    s = s >>> sh;
    if (s > 64'sh00000000FFFFFFFF) return 32'hFFFFFFFF;
    return s[31:0];
  endfunction

  task automatic send_a(input int n, input int tl, input int mode);
    int re, im, wc;
    logic [31:0] m;
    exp_pmag = '0;
    exp_pbin = 0;
    for (int i = 0; i < n; i++) begin
      if (mode == 1) begin
        if (i == 10 || i == 20) begin
          re = 8096; im = 0;
        end else begin
          re = int'($urandom_range(0, 6000)) - 3000;
          im = int'($urandom_range(0, 6000)) - 3000;
        end
      end else if (i == 0) begin
        re = 3; im = 4;
      end else if (i == 1) begin
        re = -8388608; im = -8388608;
      end else begin
        re = int'($urandom_range(0, 24'hFFFFFF)) - 8388608;
        im = int'($urandom_range(0, 24'hFFFFFF)) - 8388608;
      end
      m = mag_model(re, im, 17);
      sbq.push_back('{i, m});
      if (m > exp_pmag) begin
        exp_pmag = m;
        exp_pbin = i;
      end
      tdata  = {im[23:0], re[23:0]};
      tvalid = 1'b1;
      tlast  = (i == tl);
      wc = 0;
      while (!tready && wc < 20) begin
        @(posedge clk); #1;
        wc++;
      end
      if (!tready) begin
        fails++;
        $display("FAIL tready_timeout beat %0d got 0 want 1", i);
      end
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_frame_a();
    int c = 0;
    while (!frame_ready && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c != 3) begin
      fails++;
      $display("FAIL ready_latency got %0d want 3", c);
    end
  endtask

  task automatic drain_a();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rd_en   = 1'b1;
      rd_addr = AW'(e.addr);
      @(posedge clk); #1;
      checks++;
      if (rd_data !== e.mag) begin
        fails++;
        $display("FAIL rd_bin%0d got %h want %h", e.addr, rd_data, e.mag);
      end
      last_rd = e.mag;
    end
    rd_en = 1'b0;
  endtask

  task automatic clear_a();
    frame_clr = 1'b1;
    @(posedge clk); #1;
    frame_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 7;
    if (tready !== 1'b0) begin fails++; $display("FAIL rst_tready got %b want 0", tready); end
    if (frame_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", frame_ready); end
    if (frame_len !== '0) begin fails++; $display("FAIL rst_len got %0d want 0", frame_len); end
    if (err_e !== 1'b0) begin fails++; $display("FAIL rst_err_e got %b want 0", err_e); end
    if (err_m !== 1'b0) begin fails++; $display("FAIL rst_err_m got %b want 0", err_m); end
    if (rd_data !== '0) begin fails++; $display("FAIL rst_rd got %h want 0", rd_data); end
    if (peak_mag !== '0 || peak_bin !== '0) begin fails++; $display("FAIL rst_peak got %0d/%h want 0/0", peak_bin, peak_mag); end
    rst_n = 1'b1;
    checks++;
    if (tready !== 1'b0) begin fails++; $display("FAIL first_cycle_tready got %b want 0", tready); end
    @(posedge clk); #1;
    checks += 2;
    if (tready !== 1'b1) begin fails++; $display("FAIL post_rst_tready got %b want 1", tready); end
    if (b_tready !== 1'b1) begin fails++; $display("FAIL b_tready got %b want 1", b_tready); end
  endtask

  task automatic test_saturate();
    int re_t[4] = '{3, -8388608, 65535, -5};
    int im_t[4] = '{4, -8388608, 0, 7};
    int c, wc;
    exp_t q[$];
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      q.push_back('{i, mag_model(re_t[i], im_t[i], 0)});
      b_tdata  = {im_t[i][23:0], re_t[i][23:0]};
      b_tvalid = 1'b1;
      b_tlast  = (i == 3);
      wc = 0;
      while (!b_tready && wc < 20) begin
        @(posedge clk); #1;
        wc++;
      end
      if (!b_tready) begin fails++; $display("FAIL b_tready_timeout got 0 want 1"); end
      @(posedge clk); #1;
    end
    b_tvalid = 1'b0;
    b_tlast  = 1'b0;
    c = 0;
    while (!b_frame_ready && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    checks += 3;
    if (c != 3) begin fails++; $display("FAIL b_latency got %0d want 3", c); end
    if (b_frame_len !== 3'd4) begin fails++; $display("FAIL b_len got %0d want 4", b_frame_len); end
    if (b_err_e !== 1'b0 || b_err_m !== 1'b0) begin fails++; $display("FAIL b_err got %b%b want 00", b_err_e, b_err_m); end
`ifdef FFT_MAG_PEAK_EN
    checks++;
    if (b_peak_bin !== 2'd1 || b_peak_mag !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL b_peak got %0d/%h want 1/ffffffff", b_peak_bin, b_peak_mag);
    end
`endif
    while (q.size() > 0) begin
      e = q.pop_front();
      b_rd_en   = 1'b1;
      b_rd_addr = BAW'(e.addr);
      @(posedge clk); #1;
      checks++;
      if (b_rd_data !== e.mag) begin
        fails++; $display("FAIL b_rd_bin%0d got %h want %h", e.addr, b_rd_data, e.mag);
      end
    end
    b_rd_en = 1'b0;
    checks++;
    if (mag_model(3, 4, 0) !== 32'd25) begin fails++; $display("FAIL model_25 got %0d want 25", mag_model(3, 4, 0)); end
    b_frame_clr = 1'b1;
    @(posedge clk); #1;
    b_frame_clr = 1'b0;
  endtask

  task automatic test_full_frame();
    send_a(256, 255, 0);
    wait_frame_a();
    tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tready !== 1'b0 || frame_ready !== 1'b1) begin
        fails++; $display("FAIL ready_hold got %b/%b want 0/1", tready, frame_ready);
      end
    end
    tvalid = 1'b0;
    checks += 3;
    if (frame_len !== 9'd256) begin fails++; $display("FAIL full_len got %0d want 256", frame_len); end
    if (err_e !== 1'b0 || err_m !== 1'b0) begin fails++; $display("FAIL full_err got %b%b want 00", err_e, err_m); end
    if (sbq[1].mag !== 32'h40000000) begin fails++; $display("FAIL model_min got %h want 40000000", sbq[1].mag); end
`ifdef FFT_MAG_PEAK_EN
    checks++;
    if (peak_bin !== AW'(exp_pbin) || peak_mag !== exp_pmag) begin
      fails++; $display("FAIL full_peak got %0d/%h want %0d/%h", peak_bin, peak_mag, exp_pbin, exp_pmag);
    end
`endif
    drain_a();
    rd_addr = 8'd77;
    @(posedge clk); #1;
    checks++;
    if (rd_data !== last_rd) begin fails++; $display("FAIL rd_hold got %h want %h", rd_data, last_rd); end
    clear_a();
    checks += 2;
    if (frame_ready !== 1'b0) begin fails++; $display("FAIL clr_ready got %b want 0", frame_ready); end
    if (tready !== 1'b1) begin fails++; $display("FAIL clr_tready got %b want 1", tready); end
  endtask

  task automatic test_tlast_early();
    send_a(100, 99, 0);
    frame_clr = 1'b1;
    wait_frame_a();
    frame_clr = 1'b0;
    checks += 2;
    if (frame_len !== 9'd100) begin fails++; $display("FAIL early_len got %0d want 100", frame_len); end
    if (err_e !== 1'b1 || err_m !== 1'b0) begin fails++; $display("FAIL early_err got %b%b want 10", err_e, err_m); end
    drain_a();
    clear_a();
    checks++;
    if (err_e !== 1'b0) begin fails++; $display("FAIL early_clr got %b want 0", err_e); end
  endtask

  task automatic test_tlast_missing();
    send_a(256, -1, 0);
    wait_frame_a();
    checks += 2;
    if (frame_len !== 9'd256) begin fails++; $display("FAIL miss_len got %0d want 256", frame_len); end
    if (err_m !== 1'b1 || err_e !== 1'b0) begin fails++; $display("FAIL miss_err got %b%b want 01", err_e, err_m); end
    drain_a();
    clear_a();
    checks++;
    if (err_m !== 1'b0) begin fails++; $display("FAIL miss_clr got %b want 0", err_m); end
  endtask

  task automatic test_peak();
    send_a(256, 255, 1);
    wait_frame_a();
    checks++;
`ifdef FFT_MAG_PEAK_EN
    if (peak_bin !== 8'd10 || peak_mag !== 32'd500) begin
      fails++; $display("FAIL peak got %0d/%0d want 10/500", peak_bin, peak_mag);
    end
`else
    if (peak_bin !== '0 || peak_mag !== '0) begin
      fails++; $display("FAIL peak_off got %0d/%0d want 0/0", peak_bin, peak_mag);
    end
`endif
    stale_200 = sbq[200].mag;
    drain_a();
    clear_a();
    checks++;
    if (peak_bin !== '0 || peak_mag !== '0) begin
      fails++; $display("FAIL peak_clr got %0d/%0d want 0/0", peak_bin, peak_mag);
    end
  endtask

  task automatic test_reset_mid();
    send_a(50, -1, 0);
    rd_en   = 1'b1;
    rd_addr = 8'd200;
    @(posedge clk); #1;
    checks++;
    if (rd_data !== stale_200) begin fails++; $display("FAIL stale_rd got %h want %h", rd_data, stale_200); end
    rd_addr = 8'd10;
    @(posedge clk); #1;
    rd_en = 1'b0;
    checks++;
    if (rd_data !== sbq[10].mag) begin fails++; $display("FAIL fill_rd got %h want %h", rd_data, sbq[10].mag); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (tready !== 1'b0) begin fails++; $display("FAIL mid_tready got %b want 0", tready); end
    if (rd_data !== '0) begin fails++; $display("FAIL mid_rd got %h want 0", rd_data); end
    if (frame_len !== '0) begin fails++; $display("FAIL mid_len got %0d want 0", frame_len); end
    if (frame_ready !== 1'b0 || err_e !== 1'b0 || err_m !== 1'b0) begin
      fails++; $display("FAIL mid_flags got %b%b%b want 000", frame_ready, err_e, err_m);
    end
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_a(256, 255, 0);
    wait_frame_a();
    checks += 2;
    if (frame_len !== 9'd256) begin fails++; $display("FAIL rerun_len got %0d want 256", frame_len); end
    if (err_e !== 1'b0 || err_m !== 1'b0) begin fails++; $display("FAIL rerun_err got %b%b want 00", err_e, err_m); end
    drain_a();
    clear_a();
  endtask

  initial begin
    tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    rd_en = 1'b0; rd_addr = '0; frame_clr = 1'b0;
    b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0;
    b_rd_en = 1'b0; b_rd_addr = '0; b_frame_clr = 1'b0;
    last_rd = '0; stale_200 = '0;
    test_reset();
    test_saturate();
    test_full_frame();
    test_tlast_early();
    test_tlast_missing();
    test_peak();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
